// File: rtl/mipi_tx_pkg.sv
// Shared constants and state encoding for the D-PHY TX lane sequencer.
// SYNC_BYTE is also used by the receive-side byte aligner.
package mipi_tx_pkg;

  localparam logic [1:0] LP_STOP    = 2'b11;
  localparam logic [1:0] LP_HS_RQST = 2'b01;
  localparam logic [1:0] LP_BRIDGE  = 2'b00;

  localparam logic [7:0] SYNC_BYTE  = 8'hB8;

  typedef enum logic [2:0] {
    IDLE,
    RQST,
    PREP,
    ZERO,
    SYNC,
    DATA,
    TRAIL,
    EXIT
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mipi_tx_phase_timer.sv
// Phase duration counter: loads a cycle count, counts down to zero and holds there.
module mipi_tx_phase_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mipi_tx_lane_sequencer.sv
// MIPI D-PHY TX data-lane sequencer: LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync ->
// payload -> HS-trail -> LP-11, fed by a valid/ready byte stream.
module mipi_tx_lane_sequencer #(
  parameter int unsigned LPX_CYCLES     = 4,
  parameter int unsigned HS_ZERO_CYCLES = 10,
  parameter int unsigned TRAIL_CYCLES   = 4,
  parameter int unsigned EXIT_CYCLES    = 8,
  parameter logic [7:0]  SYNC_BYTE      = mipi_tx_pkg::SYNC_BYTE
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  input  logic       byte_last_i,
  output logic       byte_ready_o,
  output logic [7:0] byte_o,
  output logic       hs_en_o,
  output logic [1:0] lp_o,
  output logic       busy_o,
  output logic       underflow_o
);
  import mipi_tx_pkg::*;

  localparam int unsigned MAX_P = max_u(max_u(LPX_CYCLES, HS_ZERO_CYCLES),
                                        max_u(TRAIL_CYCLES, EXIT_CYCLES));
  localparam int unsigned CNT_W = $clog2(MAX_P) + 1;

  if (LPX_CYCLES == 0 || HS_ZERO_CYCLES == 0 || TRAIL_CYCLES == 0 || EXIT_CYCLES == 0)
  begin : g_param_check
    $error("mipi_tx_lane_sequencer: cycle-count parameters must be non-zero");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_drain;
  logic             w_accept;
  logic             w_underflow;
  logic             w_zero;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;

  // r_drain marks the DATA cycle that drives the last byte after ready has already dropped
  assign byte_ready_o = (r_state == SYNC) || ((r_state == DATA) && !r_drain);
  assign w_accept     = byte_ready_o && byte_valid_i;
  assign w_underflow  = byte_ready_o && !byte_valid_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (byte_valid_i) w_state_nxt = RQST;
      RQST:    if (w_zero) w_state_nxt = PREP;
      PREP:    if (w_zero) w_state_nxt = ZERO;
      ZERO:    if (w_zero) w_state_nxt = SYNC;
      SYNC:    w_state_nxt = w_underflow ? TRAIL : DATA;
      DATA:    if (r_drain || w_underflow) w_state_nxt = TRAIL;
      TRAIL:   if (w_zero) w_state_nxt = EXIT;
      EXIT:    if (w_zero) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Timer is loaded with (duration - 1) on the edge that enters a timed state
  always_comb begin
    w_load     = (w_state_nxt != r_state);
    w_load_val = '0;
    case (w_state_nxt)
      RQST, PREP: w_load_val = CNT_W'(LPX_CYCLES - 1);
      ZERO:       w_load_val = CNT_W'(HS_ZERO_CYCLES - 1);
      TRAIL:      w_load_val = CNT_W'(TRAIL_CYCLES - 1);
      EXIT:       w_load_val = CNT_W'(EXIT_CYCLES - 1);
      default:    w_load_val = '0;
    endcase
  end

  mipi_tx_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk      (clk_i),
    .i_rst      (reset_i),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= IDLE;
      r_drain     <= 1'b0;
      byte_o      <= '0;
      hs_en_o     <= 1'b0;
      lp_o        <= LP_STOP;
      busy_o      <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain     <= w_accept && byte_last_i;
      underflow_o <= w_underflow;
      busy_o      <= (w_state_nxt != IDLE);
      hs_en_o     <= (w_state_nxt inside {ZERO, SYNC, DATA, TRAIL});

      case (w_state_nxt)
        IDLE, EXIT: lp_o <= LP_STOP;
        RQST:       lp_o <= LP_HS_RQST;
        default:    lp_o <= LP_BRIDGE;
      endcase

      // Trail level is the inverse of the last bit sent, i.e. bit 7 of the byte on the lane now
      case (w_state_nxt)
        SYNC:    byte_o <= SYNC_BYTE;
        DATA:    if (w_accept) byte_o <= byte_i;
        TRAIL:   if (r_state != TRAIL) byte_o <= {8{~byte_o[7]}};
        default: byte_o <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_tx_lane_sequencer.sv
// Self-checking bench for mipi_tx_lane_sequencer: directed vector tables, reset
// aborts, and random bursts against a burst-level model with a skewed loopback receiver.
module tb_mipi_tx_lane_sequencer;

  localparam int LPX = 4;
  localparam int HZ  = 10;
  localparam int TR  = 4;
  localparam int EX  = 8;
  localparam int T_SYNC = 1 + 2 * LPX + HZ;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [7:0] byte_i;
  logic       byte_valid_i;
  logic       byte_last_i;
  logic       byte_ready_o;
  logic [7:0] byte_o;
  logic       hs_en_o;
  logic [1:0] lp_o;
  logic       busy_o;
  logic       underflow_o;

  always #5 clk = ~clk;

  mipi_tx_lane_sequencer #(
    .LPX_CYCLES     (LPX),
    .HS_ZERO_CYCLES (HZ),
    .TRAIL_CYCLES   (TR),
    .EXIT_CYCLES    (EX),
    .SYNC_BYTE      (8'hB8)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_last_i  (byte_last_i),
    .byte_ready_o (byte_ready_o),
    .byte_o       (byte_o),
    .hs_en_o      (hs_en_o),
    .lp_o         (lp_o),
    .busy_o       (busy_o),
    .underflow_o  (underflow_o)
  );

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       hs;
    logic [1:0] lp;
    logic [7:0] byt;
    logic       rdy;
    logic       busy;
    logic       uf;
  } vec_t;

  vec_t       vq[$];
  logic [7:0] pl[$];
  logic [7:0] hs_q[$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  logic [7:0] sync_b = 8'hB8;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_rows(input int cnt, input logic rnd, input logic v, input logic [7:0] d,
                          input logic l, input logic hs, input logic [1:0] lp,
                          input logic [7:0] b, input logic rdy, input logic busy, input logic uf);
    vec_t r;
    for (int i = 0; i < cnt; i++) begin
      r.valid = rnd ? 1'($urandom) : v;
      r.data  = rnd ? 8'($urandom) : d;
      r.last  = rnd ? 1'($urandom) : l;
      r.hs = hs; r.lp = lp; r.byt = b; r.rdy = rdy; r.busy = busy; r.uf = uf;
      vq.push_back(r);
    end
  endtask

  task automatic chk_vec(input string name, input int idx, input vec_t r);
    logic [13:0] act, exp;
    act = {hs_en_o, lp_o, byte_o, byte_ready_o, busy_o, underflow_o};
    exp = {r.hs, r.lp, r.byt, r.rdy, r.busy, r.uf};
    // LP line state is don't-care while the serializer owns the lane
    if (r.hs) begin
      act[12:11] = 2'b00;
      exp[12:11] = 2'b00;
    end
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] hs/lp/byte/rdy/busy/uf got %b/%b/%h/%b/%b/%b want %b/%b/%h/%b/%b/%b",
                  name, idx, hs_en_o, lp_o, byte_o, byte_ready_o, busy_o, underflow_o,
                  r.hs, r.lp, r.byt, r.rdy, r.busy, r.uf);
  endtask

  task automatic chk_idle(input string name);
    vec_t r;
    r.valid = 0; r.data = 0; r.last = 0;
    r.hs = 0; r.lp = 2'b11; r.byt = 8'h00; r.rdy = 0; r.busy = 0; r.uf = 0;
    chk_vec(name, 0, r);
  endtask

  task automatic apply_rows(input string name, input int upto);
    for (int i = 0; i < upto; i++) begin
      step();
      chk_vec(name, i, vq[i]);
      if (hs_en_o === 1'b1) hs_q.push_back(byte_o);
      byte_valid_i = vq[i].valid;
      byte_i       = vq[i].data;
      byte_last_i  = vq[i].last;
    end
  endtask

  // Burst-level model: n payload bytes, valid withdrawn when byte u is needed (u == n: no underflow)
  task automatic build_burst(input int n, input int u);
    int         m;
    logic       uf;
    logic [7:0] lastb;
    logic [7:0] tb_b;
    uf = (u < n);
    m  = uf ? u : n;
    pl.delete();
    vq.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
    add_rows(1, 0, 1, pl[0], (n == 1), 0, 2'b11, 8'h00, 0, 0, 0);
    add_rows(LPX, 1, 0, 0, 0, 0, 2'b01, 8'h00, 0, 1, 0);
    add_rows(LPX, 1, 0, 0, 0, 0, 2'b00, 8'h00, 0, 1, 0);
    add_rows(HZ, 1, 0, 0, 0, 1, 2'b00, 8'h00, 0, 1, 0);
    if (m > 0) add_rows(1, 0, 1, pl[0], (!uf && n == 1), 1, 2'b00, 8'hB8, 1, 1, 0);
    else       add_rows(1, 0, 0, 8'h5A, 1, 1, 2'b00, 8'hB8, 1, 1, 0);
    for (int k = 1; k <= m; k++) begin
      logic rdy;
      rdy = uf ? 1'b1 : (k < n);
      if (k < m)   add_rows(1, 0, 1, pl[k], (!uf && k == n - 1), 1, 2'b00, pl[k-1], rdy, 1, 0);
      else if (uf) add_rows(1, 0, 0, 8'($urandom), 1'($urandom), 1, 2'b00, pl[k-1], rdy, 1, 0);
      else         add_rows(1, 1, 0, 0, 0, 1, 2'b00, pl[k-1], rdy, 1, 0);
    end
    lastb = (m > 0) ? pl[m-1] : sync_b;
    tb_b  = {8{~lastb[7]}};
    add_rows(1, 1, 0, 0, 0, 1, 2'b00, tb_b, 0, 1, uf);
    add_rows(TR - 1, 1, 0, 0, 0, 1, 2'b00, tb_b, 0, 1, 0);
    add_rows(EX, 1, 0, 0, 0, 0, 2'b11, 8'h00, 0, 1, 0);
  endtask

  task automatic loopback(input int m);
    logic bits[$];
    logic [7:0] rx[$];
    logic [7:0] w, b;
    int skew, p;
    logic ok;
    skew = $urandom_range(0, 7);
    for (int i = 0; i < skew; i++) bits.push_back(1'($urandom));
    foreach (hs_q[j]) begin
      b = hs_q[j];
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    end
    p = 0;
    w = 8'h00;
    while (p + 8 <= bits.size()) begin
      for (int i = 0; i < 8; i++) w[i] = bits[p+i];
      if (w == 8'hB8) break;
      p++;
    end
    p += 8;
    while (p + 8 <= bits.size()) begin
      for (int i = 0; i < 8; i++) w[i] = bits[p+i];
      rx.push_back(w);
      p += 8;
    end
    for (int i = 0; i < TR && rx.size() > 0; i++) void'(rx.pop_back());
    ok = (rx.size() == m);
    for (int i = 0; i < m && ok; i++) if (rx[i] !== pl[i]) ok = 0;
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL loopback skew=%0d got %0d bytes want %0d", skew, rx.size(), m);
  endtask

  task automatic run_burst(input string name, input int n, input int u);
    hs_q.delete();
    build_burst(n, u);
    apply_rows(name, vq.size());
    loopback((u < n) ? u : n);
  endtask

  task automatic reset_abort(input string name, input int n, input int at);
    build_burst(n, n);
    apply_rows(name, at + 1);
    reset_i = 1'b1;
    step();
    chk_idle(name);
    reset_i = 1'b0;
    byte_valid_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    byte_i = 8'h00;
    byte_valid_i = 1'b0;
    byte_last_i = 1'b0;

    // Test 1: A1,52,C3 burst; Test 2: single 7F byte, back-to-back after EXIT
    add_rows(1, 0, 1, 8'hA1, 0, 0, 2'b11, 8'h00, 0, 0, 0);
    add_rows(LPX, 0, 1, 8'hA1, 0, 0, 2'b01, 8'h00, 0, 1, 0);
    add_rows(LPX, 0, 1, 8'hA1, 0, 0, 2'b00, 8'h00, 0, 1, 0);
    add_rows(HZ, 0, 1, 8'hA1, 0, 1, 2'b00, 8'h00, 0, 1, 0);
    add_rows(1, 0, 1, 8'hA1, 0, 1, 2'b00, 8'hB8, 1, 1, 0);
    add_rows(1, 0, 1, 8'h52, 0, 1, 2'b00, 8'hA1, 1, 1, 0);
    add_rows(1, 0, 1, 8'hC3, 1, 1, 2'b00, 8'h52, 1, 1, 0);
    add_rows(1, 0, 1, 8'h00, 0, 1, 2'b00, 8'hC3, 0, 1, 0);
    add_rows(TR, 0, 1, 8'h00, 0, 1, 2'b00, 8'h00, 0, 1, 0);
    add_rows(EX, 0, 1, 8'h7F, 1, 0, 2'b11, 8'h00, 0, 1, 0);
    add_rows(1 + 2 * LPX + HZ, 0, 1, 8'h7F, 1, 0, 2'b11, 8'h00, 0, 0, 0);
    for (int i = 1; i <= 2 * LPX + HZ; i++) begin
      vq[vq.size() - i].busy = 1;
      vq[vq.size() - i].lp = (i <= HZ + LPX) ? 2'b00 : 2'b01;
      vq[vq.size() - i].hs = (i <= HZ);
    end
    add_rows(1, 0, 1, 8'h7F, 1, 1, 2'b00, 8'hB8, 1, 1, 0);
    add_rows(1, 0, 0, 8'h00, 0, 1, 2'b00, 8'h7F, 0, 1, 0);
    add_rows(TR, 0, 0, 8'h00, 0, 1, 2'b00, 8'hFF, 0, 1, 0);
    add_rows(EX, 0, 0, 8'h00, 0, 0, 2'b11, 8'h00, 0, 1, 0);
    add_rows(1, 0, 0, 8'h00, 0, 0, 2'b11, 8'h00, 0, 0, 0);

    step();
    step();
    chk_idle("reset_state");
    reset_i = 1'b0;
    apply_rows("table", vq.size());

    // Test 3: valid dropped after the 2nd of 5 bytes
    run_burst("underflow_data", 5, 2);
    run_burst("underflow_sync", 3, 0);

    // Test 4: reset in ZERO, DATA and TRAIL, each followed by a fresh burst
    reset_abort("reset_zero", 4, 12);
    run_burst("after_reset_zero", 2, 2);
    reset_abort("reset_data", 4, T_SYNC + 2);
    run_burst("after_reset_data", 2, 2);
    reset_abort("reset_trail", 4, T_SYNC + 1 + 4 + 1);
    run_burst("after_reset_trail", 3, 3);

    // Tests 5/6: random bursts, back-to-back or with idle gaps, checked per cycle and via loopback
    for (int b = 0; b < 100; b++) begin
      int n, u, gap;
      n = $urandom_range(1, 8);
      u = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : n;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        step();
        chk_idle("gap_idle");
        byte_valid_i = 1'b0;
        byte_i = 8'($urandom);
        byte_last_i = 1'($urandom);
      end
      run_burst("random", n, u);
    end
    byte_valid_i = 1'b0;
    step();
    chk_idle("final_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
